// File: rtl/branch_resolver_if.sv
// Handshake bundle between fetch, the 2-bit predictor, branch resolution and the resolver.
// DEPTH and CNT_W must match the parameters of the attached branch_resolver.
interface branch_resolver_if #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
);
    logic                     br_valid;
    logic                     br_ready;
    logic                     request;
    logic                     prediction;
    logic                     pred_out;
    logic                     pred_out_valid;
    logic                     outcome_valid;
    logic                     outcome_taken;
    logic                     outcome_ready;
    logic                     result;
    logic                     taken;
    logic                     mispredict;
    logic [CNT_W-1:0]         hit_count;
    logic [CNT_W-1:0]         miss_count;
    logic [$clog2(DEPTH):0]   occupancy;

    modport slave (
        input  br_valid, prediction, outcome_valid, outcome_taken,
        output br_ready, request, pred_out, pred_out_valid, outcome_ready,
               result, taken, mispredict, hit_count, miss_count, occupancy
    );

    modport master (
        output br_valid, prediction, outcome_valid, outcome_taken,
        input  br_ready, request, pred_out, pred_out_valid, outcome_ready,
               result, taken, mispredict, hit_count, miss_count, occupancy
    );
endinterface

// File: rtl/branch_resolver.sv
// Tracks in-flight predicted branches in an in-order queue, resolves them against actual
// outcomes, flushes on mispredict and keeps saturating hit/miss statistics.
module branch_resolver #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    branch_resolver_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [OCC_W-1:0] occ;
    logic             pend_vld_p1;
    logic [PTR_W-1:0] pend_idx_p1;
    logic [DEPTH-1:0] slot_pred;
    logic [DEPTH-1:0] slot_filled;
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] miss_cnt;
    logic             result_p1;
    logic             taken_p1;
    logic             mispredict_p1;

    logic             oldest_pred;
    logic             consume;
    logic             mismatch_now;
    logic             accept;
    logic             push;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // p0: combinational resolve; an unfilled oldest slot is the one whose prediction lands now
    assign oldest_pred  = slot_filled[head_ptr] ? slot_pred[head_ptr] : bus.prediction;
    assign consume      = bus.outcome_valid & (occ != '0);
    assign mismatch_now = consume & (bus.outcome_taken != oldest_pred);
    assign accept       = (occ < OCC_W'(DEPTH)) & ~mismatch_now;
    assign push         = bus.br_valid & accept;

    assign bus.br_ready       = accept;
    assign bus.request        = push;
    assign bus.outcome_ready  = (occ != '0);
    assign bus.pred_out_valid = pend_vld_p1 & ~mismatch_now;
    assign bus.pred_out       = pend_vld_p1 & ~mismatch_now & bus.prediction;
    assign bus.result         = result_p1;
    assign bus.taken          = taken_p1;
    assign bus.mispredict     = mispredict_p1;
    assign bus.hit_count      = hit_cnt;
    assign bus.miss_count     = miss_cnt;
    assign bus.occupancy      = occ;

    // p1: queue control, update strobes and statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_ptr      <= '0;
            tail_ptr      <= '0;
            occ           <= '0;
            pend_vld_p1   <= 1'b0;
            pend_idx_p1   <= '0;
            hit_cnt       <= '0;
            miss_cnt      <= '0;
            result_p1     <= 1'b0;
            taken_p1      <= 1'b0;
            mispredict_p1 <= 1'b0;
        end else begin
            result_p1     <= consume;
            taken_p1      <= consume & bus.outcome_taken;
            mispredict_p1 <= mismatch_now;
            if (mismatch_now) begin
                // Everything younger than the resolved branch is on the wrong path
                miss_cnt    <= sat_inc(miss_cnt);
                head_ptr    <= '0;
                tail_ptr    <= '0;
                occ         <= '0;
                pend_vld_p1 <= 1'b0;
            end else begin
                if (consume) begin
                    hit_cnt  <= sat_inc(hit_cnt);
                    head_ptr <= head_ptr + PTR_W'(1);
                end
                if (push) begin
                    tail_ptr <= tail_ptr + PTR_W'(1);
                end
                pend_vld_p1 <= push;
                pend_idx_p1 <= tail_ptr;
                case ({push, consume})
                    2'b10:   occ <= occ + OCC_W'(1);
                    2'b01:   occ <= occ - OCC_W'(1);
                    default: occ <= occ;
                endcase
            end
        end
    end

    // p1: slot payload; allocation always re-initialises the filled flag
    always_ff @(posedge clk) begin
        if (push) begin
            slot_filled[tail_ptr] <= 1'b0;
        end
        if (pend_vld_p1 && !mismatch_now) begin
            slot_pred[pend_idx_p1]   <= bus.prediction;
            slot_filled[pend_idx_p1] <= 1'b1;
        end
    end
endmodule

// File: tb/tb_branch_resolver.sv
// Randomised and directed bench for branch_resolver against a queue-based reference model.
module tb_branch_resolver;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_resolver_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus();

    branch_resolver #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: outstanding predictions oldest-first, -1 = prediction not yet known
    int q[$];
    bit pend;
    int m_hit;
    int m_miss;
    bit s_brdy, s_req, s_pov, s_pout;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int oldest(input bit pr);
        if (q.size() == 0) return 0;
        return (q[0] < 0) ? int'(pr) : q[0];
    endfunction

    task automatic model_clear();
        q.delete();
        pend   = 1'b0;
        m_hit  = 0;
        m_miss = 0;
    endtask

    task automatic set_in(input bit bv, input bit pr, input bit ov, input bit ot);
        bus.br_valid      = bv;
        bus.prediction    = pr;
        bus.outcome_valid = ov;
        bus.outcome_taken = ot;
    endtask

    // Called at posedge+1; checks combinational outputs mid-cycle and registered ones after the edge
    task automatic step(input bit bv, input bit pr, input bit ov, input bit ot);
        bit ordy, old, cons, mis, brdy, req, pov;
        set_in(bv, pr, ov, ot);
        @(negedge clk);
        ordy = (q.size() > 0);
        old  = (oldest(pr) != 0);
        cons = ov && ordy;
        mis  = cons && (ot != old);
        brdy = (q.size() < DEPTH) && !mis;
        req  = bv && brdy;
        pov  = pend && !mis;
        chk("br_ready", bus.br_ready, brdy);
        chk("request", bus.request, req);
        chk("outcome_ready", bus.outcome_ready, ordy);
        chk("pred_out_valid", bus.pred_out_valid, pov);
        if (pov) chk("pred_out", bus.pred_out, pr);
        s_brdy = bus.br_ready;
        s_req  = bus.request;
        s_pov  = bus.pred_out_valid;
        s_pout = bus.pred_out;
        @(posedge clk);
        if (mis) begin
            if (m_miss < CMAX) m_miss++;
            q.delete();
            pend = 1'b0;
        end else begin
            if (pend && q.size() > 0 && q[$] < 0) q[$] = int'(pr);
            if (cons) begin
                if (m_hit < CMAX) m_hit++;
                void'(q.pop_front());
            end
            if (req) q.push_back(-1);
            pend = req;
        end
        #1;
        chk("result", bus.result, cons);
        chk("taken", bus.taken, cons && ot);
        chk("mispredict", bus.mispredict, mis);
        chk("occupancy", bus.occupancy, q.size());
        chk("hit_count", bus.hit_count, m_hit);
        chk("miss_count", bus.miss_count, m_miss);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_in(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_occupancy", bus.occupancy, 0);
        chk("rst_hit", bus.hit_count, 0);
        chk("rst_result", bus.result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        #1;
        chk("br_ready_after_rst", bus.br_ready, 1);
        @(posedge clk);
        #1;
    endtask

    // Asserts reset between edges and checks outputs clear before the next edge
    task automatic mid_reset();
        #2;
        set_in(0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("arst_result", bus.result, 0);
        chk("arst_taken", bus.taken, 0);
        chk("arst_mispredict", bus.mispredict, 0);
        chk("arst_pred_out_valid", bus.pred_out_valid, 0);
        chk("arst_pred_out", bus.pred_out, 0);
        chk("arst_occupancy", bus.occupancy, 0);
        chk("arst_hit", bus.hit_count, 0);
        chk("arst_miss", bus.miss_count, 0);
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got 0 expected 1");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit bv, pr, ov, ot, old;
        set_in(0, 0, 0, 0);

        // Single branch, predicted taken, resolves taken
        do_reset();
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        chk("s32_pred_out_valid", s_pov, 1);
        chk("s32_pred_out", s_pout, 1);
        step(0, 0, 1, 1);
        chk("s32_result", bus.result, 1);
        chk("s32_taken", bus.taken, 1);
        chk("s32_hit", bus.hit_count, 1);
        chk("s32_mispredict", bus.mispredict, 0);

        // Mispredict flush of three outstanding branches
        do_reset();
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        chk("s33_occ_before", bus.occupancy, 3);
        step(0, 0, 1, 0);
        chk("s33_mispredict", bus.mispredict, 1);
        chk("s33_occ_after", bus.occupancy, 0);
        chk("s33_miss", bus.miss_count, 1);
        step(0, 0, 1, 1);
        chk("s33_no_result", bus.result, 0);
        chk("s33_hit", bus.hit_count, 0);

        // Queue full blocks the fifth request until one resolves
        do_reset();
        repeat (4) step(1, 1, 0, 0);
        chk("s34_occ_full", bus.occupancy, 4);
        step(1, 1, 0, 0);
        chk("s34_br_ready_full", s_brdy, 0);
        chk("s34_request_full", s_req, 0);
        chk("s34_occ_still_full", bus.occupancy, 4);
        step(0, 0, 1, 1);
        step(1, 1, 0, 0);
        chk("s34_br_ready_again", s_brdy, 1);

        // Outcome arrives in the same cycle as the prediction
        do_reset();
        step(1, 0, 0, 0);
        step(0, 1, 1, 1);
        chk("s35_hit", bus.hit_count, 1);
        chk("s35_occ", bus.occupancy, 0);

        // Push and pop together: matching keeps occupancy, mismatching flushes
        do_reset();
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        step(0, 0, 0, 0);
        chk("s36_occ_two", bus.occupancy, 2);
        step(1, 1, 1, 1);
        chk("s36_occ_kept", bus.occupancy, 2);
        step(1, 0, 1, 1);
        chk("s36_br_ready_mis", s_brdy, 0);
        chk("s36_occ_flushed", bus.occupancy, 0);

        // Asynchronous reset with three branches outstanding
        do_reset();
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(1, 1, 1, 1);
        chk("s37_occ_before", bus.occupancy, 3);
        mid_reset();
        step(0, 0, 1, 1);
        chk("s37_ignored_result", bus.result, 0);
        chk("s37_ignored_hit", bus.hit_count, 0);

        // Randomised traffic, mostly correct predictions, with occasional async resets
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            bv  = ($urandom_range(0, 9) < 6);
            pr  = $urandom_range(0, 1);
            ov  = ($urandom_range(0, 1) == 1);
            old = (oldest(pr) != 0);
            if (q.size() == 0) ot = $urandom_range(0, 1);
            else ot = ($urandom_range(0, 4) == 0) ? !old : old;
            step(bv, pr, ov, ot);
            if (i % 700 == 350) mid_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
